cu_mod0_1: RTL and testbench
============================

// Module: cu_mod0_1
// PURPOSE
//  Control unit for FFT module-0 stage 1 (BF2II), directly downstream of cu_mod0_0.
//  - Armed by alert_mod01 and counts samples flagged by valid_fac8_0.
//  - Drives the stage-1 butterfly select (bf_en), the output-aligned valid and the twiddle index.
//  - Emits alert_mod02 to arm the next stage's control unit.
// PARAMETERS
//  BLK_LEN  32  samples per frame at this stage (power of 2)
//  BF_HALF   8  half-period of bf_en (delay-line depth of BF2II; power of 2, < BLK_LEN)
//  LAT       2  butterfly datapath pipeline latency after the delay line, in cycles
//  CW        $clog2(BLK_LEN)  local, sample-counter width
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  alert_mod01   in   1   1-cycle pulse from cu_mod0_0, coincident with the first valid_fac8_0
//  valid_fac8_0  in   1   upstream sample valid; one sample per cycle when high
//  bf_en         out  1   stage-1 butterfly enable (0 = load delay line, 1 = add/sub)
//  valid_out     out  1   stage-1 output sample valid
//  tw_idx        out  CW  twiddle ROM index aligned to valid_out
//  alert_mod02   out  1   1-cycle pulse with the first valid_out of a burst
//  busy          out  1   high while the FSM is not IDLE or the valid pipe is non-empty
//  err_overrun   out  1   sticky: alert_mod01 received outside IDLE/DRAIN
// BEHAVIOUR
//  - All outputs are registered and reset to 0; cnt = 0, state = IDLE. Reset mid-frame aborts at once.
//  - D = BF_HALF + LAT (default 10).
//  - Accept: a sample at cycle t is accepted when valid_fac8_0 = 1 and state = RUN,
//    or when state = IDLE/DRAIN and alert_mod01 = 1 in the same cycle.
//  - FSM IDLE:
//      * alert_mod01 & valid_fac8_0 -> RUN; this sample is cnt = 0.
//      * valid_fac8_0 without alert is ignored.
//      * alert_mod01 without valid is ignored (no state change).
//  - FSM RUN:
//      * each accepted sample: cnt <= cnt + 1 (wraps BLK_LEN-1 -> 0).
//      * valid low mid-frame: cnt, bf_en and state hold (gap is allowed).
//      * last sample accepted (cnt = BLK_LEN-1) and valid_fac8_0 low in the next cycle -> DRAIN.
//      * valid_fac8_0 still high in the next cycle -> stay in RUN (back-to-back frame).
//  - FSM DRAIN:
//      * counts D cycles.
//      * valid_fac8_0 high during DRAIN -> RUN; this sample is cnt = 0 and does not need an alert.
//      * alert_mod01 during DRAIN is also legal.
//      * D cycles with no sample -> IDLE.
//  - bf_en at t+1 = cnt[$clog2(BF_HALF)] of the sample accepted at t.
//      * Holds its value in cycles with no accepted sample.
//      * Default pattern: 0 for 8 samples, 1 for 8, 0 for 8, 1 for 8.
//  - Valid pipe: valid_out at t+D = accepted(t).
//      * Gaps propagate unchanged.
//      * The pipe keeps shifting in every state except under reset.
//  - tw_idx:
//      * increments after each valid_out cycle, wrapping BLK_LEN-1 -> 0.
//      * reset to 0 when the FSM enters IDLE.
//      * equals the output sample index while valid_out = 1.
//  - alert_mod02:
//      * The accept that leaves IDLE tags its sample with a first marker carried alongside valid.
//      * alert_mod02 = 1 in exactly the cycle that marker exits (t+D), so it coincides with the first valid_out.
//      * DRAIN -> RUN re-entry produces no new tag.
//  - err_overrun is set by alert_mod01 while in RUN.
//      * The alert is otherwise ignored (cnt unaffected).
//      * Cleared only by rst.
//  - busy = (state != IDLE) | (any valid-pipe stage set).
// STRUCTURE
//  - Package fft_mod0_pkg:
//      * typedef enum logic [1:0] {IDLE, RUN, DRAIN} cu_state_e
//      * default constants MOD0_BLK_LEN and MOD0_BF_HALF
//  - Sub-module valid_dly_line #(.DEPTH(D), .W(2)): shift register carrying {first, valid}, async active-high reset.
//  - Top level: FSM, sample counter, bf_en register, tw_idx counter, error flag.
// TESTING (BLK_LEN=32, BF_HALF=8, LAT=2, D=10)
//  1. rst=1 held 5 cycles with random inputs -> all outputs 0; release with valid_fac8_0 high and no alert -> outputs stay 0.
//  2. alert+valid at t0, then 32 contiguous samples:
//     -> bf_en 0@t0+1..8, 1@9..16, 0@17..24, 1@25..32
//     -> valid_out t0+10..t0+41; tw_idx 0..31; alert_mod02 only at t0+10
//     -> IDLE and busy=0 at t0+43.
//  3. Same as 2 with valid low for 2 cycles after sample 12 -> bf_en holds 1; valid_out has a 2-cycle hole at t0+23..24; tw_idx continuous.
//  4. 64 contiguous samples -> bf_en period 16 without break; tw_idx wraps 31->0 at t0+42; one alert_mod02; no DRAIN until t0+64.
//  5. rst pulse at sample 20 -> outputs 0 immediately; a new alert at t1 reproduces scenario 2 timing relative to t1.
//  6. alert_mod01 at sample 5 in RUN -> err_overrun=1 from the next cycle onward; bf_en and valid_out timing identical to scenario 2.

Source files
------------

// File: rtl/fft_mod0_pkg.sv
// Shared types and default constants for the FFT module-0 control units.
package fft_mod0_pkg;

  localparam int unsigned MOD0_BLK_LEN = 32;
  localparam int unsigned MOD0_BF_HALF = 8;
  localparam int unsigned MOD0_LAT     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cu_state_e;

  // Tag carried alongside each sample through the output-alignment pipe
  typedef struct packed {
    logic first;
    logic valid;
  } vld_tag_t;

endpackage

// File: rtl/valid_dly_line.sv
// Fixed-depth shift register aligning sample tags with the butterfly output.
module valid_dly_line #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         occ_next_c
);

  logic [W-1:0] pipe [DEPTH];

  // Shift every cycle; only reset stops the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

  // Valid bit (bit 0) present anywhere in the pipe after the coming edge
  always_comb begin
    occ_next_c = din[0];
    for (int unsigned i = 0; i + 1 < DEPTH; i++) occ_next_c = occ_next_c | pipe[i][0];
  end

endmodule

// File: rtl/cu_mod0_1.sv
// Control unit for FFT module-0 stage 1 (BF2II): butterfly select, aligned valid, twiddle index.
module cu_mod0_1
  import fft_mod0_pkg::*;
#(
  parameter int unsigned BLK_LEN = MOD0_BLK_LEN,
  parameter int unsigned BF_HALF = MOD0_BF_HALF,
  parameter int unsigned LAT     = MOD0_LAT,
  localparam int unsigned CW     = $clog2(BLK_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alert_mod01,
  input  logic          valid_fac8_0,
  output logic          bf_en,
  output logic          valid_out,
  output logic [CW-1:0] tw_idx,
  output logic          alert_mod02,
  output logic          busy,
  output logic          err_overrun
);

  localparam int unsigned D  = BF_HALF + LAT;
  localparam int unsigned DW = $clog2(D);
  localparam int unsigned BB = $clog2(BF_HALF);

  cu_state_e     state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;

  logic          start_c;
  logic          acc_c;
  logic          drain_done_c;
  logic          idle_next_c;
  logic          occ_next_c;
  logic [CW-1:0] smp_cnt_c;
  vld_tag_t      tag_in;
  vld_tag_t      tag_out;

  // Sample acceptance and the index the accepted sample carries
  always_comb begin
    start_c      = (state == IDLE) && alert_mod01 && valid_fac8_0;
    acc_c        = start_c || ((state != IDLE) && valid_fac8_0);
    smp_cnt_c    = (state == RUN) ? cnt : '0;
    drain_done_c = (state == DRAIN) && !valid_fac8_0 && (dcnt == DW'(D - 1));
    idle_next_c  = ((state == IDLE) && !start_c) || drain_done_c;
    tag_in.first = start_c;
    tag_in.valid = acc_c;
  end

  // Frame FSM with sample counter and drain timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      if (acc_c) cnt <= smp_cnt_c + CW'(1);
      case (state)
        IDLE: begin
          if (start_c) state <= RUN;
        end
        RUN: begin
          // cnt wrapped to 0 means a whole frame was accepted
          if (!valid_fac8_0 && (cnt == '0)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          if (valid_fac8_0)      state <= RUN;
          else if (drain_done_c) state <= IDLE;
          else                   dcnt  <= dcnt + DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs: butterfly select, twiddle index, busy, sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_en       <= 1'b0;
      tw_idx      <= '0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (acc_c) bf_en <= smp_cnt_c[BB];
      if (drain_done_c)   tw_idx <= '0;
      else if (valid_out) tw_idx <= tw_idx + CW'(1);
      busy <= !idle_next_c || occ_next_c;
      if ((state == RUN) && alert_mod01) err_overrun <= 1'b1;
    end
  end

  valid_dly_line #(
    .DEPTH (D),
    .W     (2)
  ) u_dly (
    .clk        (clk),
    .rst        (rst),
    .din        (tag_in),
    .dout       (tag_out),
    .occ_next_c (occ_next_c)
  );

  assign valid_out   = tag_out.valid;
  assign alert_mod02 = tag_out.first;

endmodule

// File: tb/tb_cu_mod0_1.sv
// Randomized bench for cu_mod0_1 against a frame-level reference model.
module tb_cu_mod0_1;

  localparam int BLK = 32;
  localparam int BFH = 8;
  localparam int D   = 10;
  localparam int NH  = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alert_mod01 = 1'b0;
  logic       valid_fac8_0 = 1'b0;
  logic       bf_en, valid_out, alert_mod02, busy, err_overrun;
  logic [4:0] tw_idx;

  cu_mod0_1 dut (
    .clk          (clk),
    .rst          (rst),
    .alert_mod01  (alert_mod01),
    .valid_fac8_0 (valid_fac8_0),
    .bf_en        (bf_en),
    .valid_out    (valid_out),
    .tw_idx       (tw_idx),
    .alert_mod02  (alert_mod02),
    .busy         (busy),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: burst activity, samples taken in burst, last accept time
  bit m_active;
  int m_k;
  int m_last;
  bit m_bf;
  int m_tw;
  bit m_err;
  bit acc_h   [NH];
  bit first_h [NH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit hist_acc(input int c);
    return (c >= 0) ? acc_h[c] : 1'b0;
  endfunction

  function automatic bit hist_first(input int c);
    return (c >= 0) ? first_h[c] : 1'b0;
  endfunction

  task automatic compare();
    bit eb;
    eb = m_active;
    for (int j = 1; j <= D; j++) eb |= hist_acc(cyc - j);
    check_eq("valid_out",   32'(valid_out),   32'(hist_acc(cyc - D)));
    check_eq("alert_mod02", 32'(alert_mod02), 32'(hist_first(cyc - D)));
    check_eq("bf_en",       32'(bf_en),       32'(m_bf));
    check_eq("tw_idx",      32'(tw_idx),      32'(m_tw));
    check_eq("busy",        32'(busy),        32'(eb));
    check_eq("err_overrun", 32'(err_overrun), 32'(m_err));
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_last   = -1000;
    m_bf     = 1'b0;
    m_tw     = 0;
    m_err    = 1'b0;
    for (int j = 0; j <= D; j++) begin
      if (cyc - j >= 0) begin
        acc_h[cyc - j]   = 1'b0;
        first_h[cyc - j] = 1'b0;
      end
    end
  endtask

  // Apply one cycle's inputs to the model
  task automatic model_update(input bit a, input bit v);
    bit acc, fst, go_idle, run_now;
    acc = 0; fst = 0; go_idle = 0;
    if (!m_active) begin
      if (a && v) begin
        acc = 1; fst = 1; m_active = 1; m_k = 1; m_last = cyc; m_bf = 0;
      end
    end else begin
      // Frame done and at least one empty cycle since: the unit is draining
      run_now = !(((m_k % BLK) == 0) && (cyc - m_last >= 2));
      if (a && run_now) m_err = 1;
      if (v) begin
        acc    = 1;
        m_bf   = (((m_k % BLK) / BFH) % 2) == 1;
        m_k++;
        m_last = cyc;
      end else if (((m_k % BLK) == 0) && (cyc - m_last >= D + 1)) begin
        go_idle = 1;
      end
    end
    if (hist_acc(cyc - D)) m_tw = (m_tw + 1) % BLK;
    if (go_idle) begin
      m_active = 0;
      m_tw     = 0;
    end
    acc_h[cyc]   = acc;
    first_h[cyc] = fst;
  endtask

  task automatic guard();
    if (cyc >= NH - 1) begin
      $display("FAIL cycle_budget cyc=%0d got=overflow exp=<%0d", cyc, NH);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic step(input bit a, input bit v);
    @(negedge clk);
    guard();
    compare();
    rst = 1'b0; alert_mod01 = a; valid_fac8_0 = v;
    model_update(a, v);
    cyc++;
  endtask

  // One cycle under reset; outputs must clear at once
  task automatic rst_cycle();
    @(negedge clk);
    guard();
    compare();
    rst = 1'b1;
    alert_mod01  = 1'($urandom);
    valid_fac8_0 = 1'($urandom);
    #1;
    model_reset();
    compare();
    acc_h[cyc] = 0; first_h[cyc] = 0;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic burst(input int n, input int gap_after, input int gap_len, input int alert_at);
    for (int i = 0; i < n; i++) begin
      step((i == 0) || (i == alert_at), 1'b1);
      if (i == gap_after) for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    int mode, len;
    model_reset();
    // Reset with random inputs, then release with valid but no alert
    for (int i = 0; i < 5; i++) rst_cycle();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle_cycles(2);
    // Single frame, frame with gap, double frame
    burst(32, -1, 0, -1);   idle_cycles(15);
    burst(32, 12, 2, -1);   idle_cycles(15);
    burst(64, -1, 0, -1);   idle_cycles(15);
    // Reset mid-frame, then a clean frame
    burst(20, -1, 0, -1);
    rst_cycle();
    idle_cycles(3);
    burst(32, -1, 0, -1);   idle_cycles(15);
    // Overrun alert at sample 5
    burst(32, -1, 0, 5);    idle_cycles(15);
    // Re-entry from drain without alert
    burst(32, -1, 0, -1);   idle_cycles(4);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1);
    idle_cycles(15);
    // Randomized traffic
    rst_cycle();
    for (int blk = 0; blk < 60; blk++) begin
      mode = int'($urandom_range(0, 9));
      len  = int'($urandom_range(10, 80));
      if (mode == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) rst_cycle();
      end else if (mode <= 3) begin
        for (int i = 0; i < len; i++)
          step(($urandom % 8) == 0, ($urandom % 8) == 0);
      end else if (mode <= 6) begin
        for (int i = 0; i < len; i++)
          step(($urandom % 40) == 0 || i == 0, ($urandom % 10) != 0);
      end else begin
        burst(BLK * int'($urandom_range(1, 3)), int'($urandom_range(0, 40)) - 8,
              int'($urandom_range(1, 4)), int'($urandom_range(0, 60)) - 30);
        idle_cycles(int'($urandom_range(0, 16)));
      end
    end
    idle_cycles(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
